stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 125 ++++++++++++
 tb/tb_stack_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO controller in front of a registered-read word RAM.
// Ports: clk, rst_n (async low); push/pop/push_data/err_clr requests;
// ready, pop_valid, pop_data, empty, full, depth, err, err_code status;
// ram_we, ram_addr, ram_din, ram_dout to the external RAM.
module stack_ctrl #(
    parameter int CPU_BIT_WIDTH = 32,
    parameter int DEPTH_BITS    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [CPU_BIT_WIDTH-1:0] push_data,
    input  logic                     err_clr,
    output logic                     ready,
    output logic                     pop_valid,
    output logic [CPU_BIT_WIDTH-1:0] pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [DEPTH_BITS:0]      depth,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic                     ram_we,
    output logic [CPU_BIT_WIDTH-1:0] ram_addr,
    output logic [CPU_BIT_WIDTH-1:0] ram_din,
    input  logic [CPU_BIT_WIDTH-1:0] ram_dout
);

    typedef enum logic {
        IDLE,
        POP_WAIT
    } state_t;

    localparam logic [1:0] E_OVF = 2'b01;
    localparam logic [1:0] E_UNF = 2'b10;
    localparam logic [1:0] E_CFL = 2'b11;

    localparam int unsigned CAP_I = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] CAP = CAP_I[DEPTH_BITS:0];
    localparam logic [DEPTH_BITS:0] ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

    state_t              state;
    logic [DEPTH_BITS:0] sp;

    logic                is_idle;
    logic                do_push;
    logic                do_pop;
    logic                ovf;
    logic                unf;
    logic                cfl;
    logic                new_err;
    logic [1:0]          new_code;
    logic [DEPTH_BITS:0] addr_idx;

    assign is_idle = (state == IDLE);
    assign empty   = (sp == '0);
    assign full    = (sp == CAP);
    assign depth   = sp;
    assign ready   = is_idle;

    assign do_push = is_idle & push & ~pop & ~full;
    assign do_pop  = is_idle & pop & ~push & ~empty;
    assign ovf     = is_idle & push & ~pop & full;
    assign unf     = is_idle & pop & ~push & empty;
    assign cfl     = is_idle & push & pop;
    assign new_err = ovf | unf | cfl;

    always_comb begin
        new_code = 2'b00;
        unique case (1'b1)
            ovf:     new_code = E_OVF;
            unf:     new_code = E_UNF;
            cfl:     new_code = E_CFL;
            default: new_code = 2'b00;
        endcase
    end

    // Pop addresses the top entry (sp-1); the RAM returns it one edge
    // later, by which time sp has already been decremented to match.
    assign addr_idx = do_pop ? (sp - ONE) : sp;
    assign ram_addr = CPU_BIT_WIDTH'(addr_idx);
    assign ram_din  = push_data;
    // Gate with rst_n so a held push cannot write while in reset.
    assign ram_we   = rst_n & do_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sp        <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            pop_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (do_push) begin
                        sp <= sp + ONE;
                    end else if (do_pop) begin
                        sp    <= sp - ONE;
                        state <= POP_WAIT;
                    end
                end
                POP_WAIT: begin
                    pop_data  <= ram_dout;
                    pop_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Sticky first error; a clear in the same cycle as a new
            // error lets the new error through.
            if (err_clr) begin
                err      <= new_err;
                err_code <= new_code;
            end else if (!err && new_err) begin
                err      <= 1'b1;
                err_code <= new_code;
            end
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed self-checking bench for stack_ctrl.
// Models a 256-word registered-read RAM behind the controller.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [31:0] push_data = '0;
    logic        err_clr = 1'b0;
    logic        ready;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic        empty;
    logic        full;
    logic [8:0]  depth;
    logic        err;
    logic [1:0]  err_code;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;

    logic [31:0] mem [256];

    int checks = 0;
    int failures = 0;

    stack_ctrl #(.CPU_BIT_WIDTH(32), .DEPTH_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .push_data(push_data), .err_clr(err_clr), .ready(ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .empty(empty),
        .full(full), .depth(depth), .err(err), .err_code(err_code),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_din;
        ram_dout <= mem[ram_addr[7:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 0; pop = 0; err_clr = 0;
        rst_n = 0;
        #2;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic do_push(input logic [31:0] v);
        push = 1; push_data = v;
        step();
        push = 0;
    endtask

    // Returns popped data and whether handshake timing was as expected.
    task automatic do_pop(output logic [31:0] d, output bit ok);
        pop = 1;
        step();
        pop = 0;
        ok = (ready == 0) && (pop_valid == 0);
        step();
        ok = ok && (pop_valid == 1) && (ready == 1);
        d = pop_data;
        step();
        ok = ok && (pop_valid == 0);
    endtask

    task automatic test_reset();
        rst_n = 0; push = 1; push_data = 32'h77;
        step();
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", ram_we); end
        checks++; if (depth !== 9'd0) begin failures++; $display("FAIL rst_depth got=%0d exp=0", depth); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=10", empty, full); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
        checks++; if (pop_valid !== 1'b0 || pop_data !== 32'h0) begin failures++; $display("FAIL rst_pop got=%b/%h exp=0/0", pop_valid, pop_data); end
        checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL rst_err got=%b/%b exp=0/00", err, err_code); end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 32'd0) begin failures++; $display("FAIL first_we got=%b/%h exp=1/0", ram_we, ram_addr); end
        step();
        push = 0;
        checks++; if (depth !== 9'd1) begin failures++; $display("FAIL first_push got=%0d exp=1", depth); end
    endtask

    task automatic test_lifo();
        logic [31:0] d;
        bit ok;
        logic [31:0] vals [3];
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push = 1; push_data = vals[i];
            #1;
            checks++; if (ram_we !== 1'b1 || ram_addr !== i) begin failures++; $display("FAIL lifo_wr%0d got=%b/%h exp=1/%h", i, ram_we, ram_addr, i); end
            step();
            push = 0;
        end
        checks++; if (depth !== 9'd3) begin failures++; $display("FAIL lifo_depth got=%0d exp=3", depth); end
        pop = 1;
        #1;
        checks++; if (ram_we !== 1'b0 || ram_addr !== 32'd2) begin failures++; $display("FAIL lifo_paddr got=%b/%h exp=0/2", ram_we, ram_addr); end
        for (int i = 2; i >= 0; i--) begin
            do_pop(d, ok);
            checks++; if (d !== vals[i] || !ok) begin failures++; $display("FAIL lifo_pop%0d got=%h/%b exp=%h/1", i, d, ok, vals[i]); end
        end
        checks++; if (empty !== 1'b1 || depth !== 9'd0) begin failures++; $display("FAIL lifo_empty got=%b/%0d exp=1/0", empty, depth); end
    endtask

    task automatic test_full();
        logic [31:0] d;
        bit ok;
        do_reset();
        for (int i = 0; i < 256; i++) do_push(i);
        checks++; if (full !== 1'b1 || depth !== 9'd256) begin failures++; $display("FAIL full_flag got=%b/%0d exp=1/256", full, depth); end
        push = 1; push_data = 32'hDEAD;
        #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL ovf_we got=%b exp=0", ram_we); end
        step();
        push = 0;
        checks++; if (err !== 1'b1 || err_code !== 2'b01) begin failures++; $display("FAIL ovf_err got=%b/%b exp=1/01", err, err_code); end
        checks++; if (depth !== 9'd256) begin failures++; $display("FAIL ovf_depth got=%0d exp=256", depth); end
        do_pop(d, ok);
        checks++; if (d !== 32'd255 || !ok) begin failures++; $display("FAIL full_pop got=%h/%b exp=ff/1", d, ok); end
        checks++; if (full !== 1'b0 || depth !== 9'd255) begin failures++; $display("FAIL full_after got=%b/%0d exp=0/255", full, depth); end
    endtask

    task automatic test_underflow();
        bit seen;
        do_reset();
        pop = 1;
        #1;
        checks++; if (ram_we !== 1'b0 || ram_addr !== 32'd0) begin failures++; $display("FAIL unf_ram got=%b/%h exp=0/0", ram_we, ram_addr); end
        step();
        pop = 0;
        seen = pop_valid;
        checks++; if (err !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL unf_err got=%b/%b exp=1/10", err, err_code); end
        checks++; if (depth !== 9'd0 || ready !== 1'b1) begin failures++; $display("FAIL unf_state got=%0d/%b exp=0/1", depth, ready); end
        step(); seen |= pop_valid;
        step(); seen |= pop_valid;
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL unf_valid got=%b exp=0", seen); end
        push = 1; pop = 1;
        step();
        push = 0; pop = 0;
        checks++; if (err_code !== 2'b10) begin failures++; $display("FAIL sticky got=%b exp=10", err_code); end
        err_clr = 1; push = 1; pop = 1;
        step();
        push = 0; pop = 0;
        checks++; if (err !== 1'b1 || err_code !== 2'b11) begin failures++; $display("FAIL clr_new got=%b/%b exp=1/11", err, err_code); end
        step();
        err_clr = 0;
        checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL clr got=%b/%b exp=0/00", err, err_code); end
    endtask

    task automatic test_conflict();
        do_reset();
        do_push(32'h1); do_push(32'h2); do_push(32'h3);
        push = 1; pop = 1; push_data = 32'h99;
        #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL cfl_we got=%b exp=0", ram_we); end
        step();
        push = 0; pop = 0;
        checks++; if (depth !== 9'd3 || ready !== 1'b1) begin failures++; $display("FAIL cfl_depth got=%0d/%b exp=3/1", depth, ready); end
        checks++; if (err !== 1'b1 || err_code !== 2'b11) begin failures++; $display("FAIL cfl_err got=%b/%b exp=1/11", err, err_code); end
        checks++; if (mem[2] !== 32'h3) begin failures++; $display("FAIL cfl_mem got=%h exp=3", mem[2]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bit ok;
        do_reset();
        do_push(32'h11); do_push(32'h22);
        pop = 1;
        step();
        pop = 0; push = 1; push_data = 32'h55;
        #1;
        checks++; if (ready !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL b2b_wait got=%b/%b exp=0/0", ready, ram_we); end
        checks++; if (depth !== 9'd1 || ram_addr !== 32'd1) begin failures++; $display("FAIL b2b_sp got=%0d/%h exp=1/1", depth, ram_addr); end
        step();
        checks++; if (pop_valid !== 1'b1 || pop_data !== 32'h22) begin failures++; $display("FAIL b2b_pop got=%b/%h exp=1/22", pop_valid, pop_data); end
        checks++; if (ram_we !== 1'b1 || ram_addr !== 32'd1) begin failures++; $display("FAIL b2b_push got=%b/%h exp=1/1", ram_we, ram_addr); end
        step();
        push = 0;
        checks++; if (depth !== 9'd2 || mem[1] !== 32'h55) begin failures++; $display("FAIL b2b_mem got=%0d/%h exp=2/55", depth, mem[1]); end
        checks++; if (pop_valid !== 1'b0 || pop_data !== 32'h22) begin failures++; $display("FAIL b2b_hold got=%b/%h exp=0/22", pop_valid, pop_data); end
        do_pop(d, ok);
        checks++; if (d !== 32'h55 || !ok) begin failures++; $display("FAIL b2b_repop got=%h/%b exp=55/1", d, ok); end
    endtask

    task automatic test_reset_popwait();
        bit seen;
        do_push(32'h66);
        pop = 1;
        step();
        pop = 0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rpw_wait got=%b exp=0", ready); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (depth !== 9'd0 || ready !== 1'b1) begin failures++; $display("FAIL rpw_async got=%0d/%b exp=0/1", depth, ready); end
        checks++; if (pop_valid !== 1'b0 || pop_data !== 32'h0) begin failures++; $display("FAIL rpw_pop got=%b/%h exp=0/0", pop_valid, pop_data); end
        checks++; if (err !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL rpw_err got=%b/%b exp=0/0", err, ram_we); end
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen |= pop_valid;
        end
        checks++; if (seen !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL rpw_after got=%b/%b exp=0/1", seen, empty); end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_full();
        test_underflow();
        test_conflict();
        test_back_to_back();
        test_reset_popwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
